// File: rtl/sdram_pkg.sv
// Shared SDRAM definitions: command pin encodings and arbiter state encoding,
// used by the init, refresh, write, read and arbiter blocks.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_t;

  function automatic logic is_rd_cmd(input logic [3:0] cmd);
    return (cmd == CMD_RD);
  endfunction

endpackage

// File: rtl/sdram_rd_capture.sv
// Read-data capture: delays READ command detection by CAS latency, then
// registers BURST_LEN words from DQ with a valid strobe.
module sdram_rd_capture
  import sdram_pkg::*;
#(
  parameter int CAS_LAT   = 3,
  parameter int BURST_LEN = 4,
  parameter int DATA_W    = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              rd_cmd_det,
  input  logic [DATA_W-1:0] sdram_dq_in,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_vld
);

  localparam int               CNT_W     = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);

  logic [CAS_LAT-1:0] cas_pipe_p0;
  logic [CAS_LAT-1:0] cas_pipe_nxt;
  logic [CNT_W-1:0]   burst_cnt_p1;
  logic [CNT_W-1:0]   cnt_eff;

  always_comb begin
    cas_pipe_nxt    = cas_pipe_p0 << 1;
    cas_pipe_nxt[0] = rd_cmd_det;
  end

  // Stage p0: CAS-latency delay line of the READ command detection
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) cas_pipe_p0 <= '0;
    else         cas_pipe_p0 <= cas_pipe_nxt;
  end

  // A fresh READ emerging from the delay line reloads the count, which is what
  // makes back-to-back bursts seamless; its first word is the one on DQ now.
  assign cnt_eff = cas_pipe_p0[CAS_LAT-1] ? BURST_CNT : burst_cnt_p1;

  // Stage p1: burst counter and data register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      burst_cnt_p1 <= '0;
      rd_data      <= '0;
      rd_data_vld  <= 1'b0;
    end else if (cnt_eff != '0) begin
      burst_cnt_p1 <= cnt_eff - CNT_W'(1);
      rd_data      <= sdram_dq_in;
      rd_data_vld  <= 1'b1;
    end else begin
      rd_data_vld  <= 1'b0;
    end
  end

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM arbiter: fixed-priority grant (refresh > write > read), command/DQ
// mux onto the SDRAM pins, and read-data capture toward the FIR path.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int CAS_LAT   = 3,
  parameter int BURST_LEN = 4,
  parameter int DATA_W    = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              init_end,
  input  logic [3:0]        init_cmd,
  input  logic [1:0]        init_ba,
  input  logic [11:0]       init_addr,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [11:0]       aref_addr,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [1:0]        wr_ba,
  input  logic [11:0]       wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_data_oe,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [1:0]        rd_ba,
  input  logic [11:0]       rd_addr,
  output logic              aref_en,
  output logic              wr_en,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [1:0]        sdram_ba,
  output logic [11:0]       sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe,
  input  logic [DATA_W-1:0] sdram_dq_in,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_data_vld
);

  arb_state_t  state, state_nxt;
  logic [3:0]  cmd_mux;
  logic [1:0]  ba_mux;
  logic [11:0] addr_mux;
  logic        rd_cmd_det;

  // Grants are registered from the next state so they line up with state.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state   <= ST_INIT;
      aref_en <= 1'b0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
    end else begin
      state   <= state_nxt;
      aref_en <= (state_nxt == ST_AREF);
      wr_en   <= (state_nxt == ST_WRITE);
      rd_en   <= (state_nxt == ST_READ);
    end
  end

  // Owners release only through their own *_end pulse; no pre-emption.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:  if (init_end) state_nxt = ST_ARBIT;
      ST_ARBIT: begin
        if (aref_req)     state_nxt = ST_AREF;
        else if (wr_req)  state_nxt = ST_WRITE;
        else if (rd_req)  state_nxt = ST_READ;
      end
      ST_AREF:  if (aref_end) state_nxt = ST_ARBIT;
      ST_WRITE: if (wr_end)   state_nxt = ST_ARBIT;
      ST_READ:  if (rd_end)   state_nxt = ST_ARBIT;
      default:  state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    cmd_mux  = CMD_NOP;
    ba_mux   = 2'b00;
    addr_mux = 12'h000;
    case (state)
      ST_INIT: begin
        cmd_mux  = init_cmd;
        ba_mux   = init_ba;
        addr_mux = init_addr;
      end
      ST_AREF: begin
        cmd_mux  = aref_cmd;
        addr_mux = aref_addr;
      end
      ST_WRITE: begin
        cmd_mux  = wr_cmd;
        ba_mux   = wr_ba;
        addr_mux = wr_addr;
      end
      ST_READ: begin
        cmd_mux  = rd_cmd;
        ba_mux   = rd_ba;
        addr_mux = rd_addr;
      end
      default: ;
    endcase
  end

  assign sdram_cke = 1'b1;
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_mux;
  assign sdram_ba     = ba_mux;
  assign sdram_addr   = addr_mux;
  assign sdram_dq_out = wr_data;
  assign sdram_dq_oe  = wr_data_oe && (state == ST_WRITE);

  assign rd_cmd_det = (state == ST_READ) && is_rd_cmd(cmd_mux);

  sdram_rd_capture #(
    .CAS_LAT   (CAS_LAT),
    .BURST_LEN (BURST_LEN),
    .DATA_W    (DATA_W)
  ) u_rd_capture (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .rd_cmd_det  (rd_cmd_det),
    .sdram_dq_in (sdram_dq_in),
    .rd_data     (rd_data),
    .rd_data_vld (rd_data_vld)
  );

endmodule

// File: doc/sdram_arbit.md
Name: sdram_arbit

Overview:
- Central SDRAM controller stage between the init, auto-refresh, write and read sub-modules and the SDRAM pins.
- Grants exactly one requester at a time using fixed priority: refresh > write > read.
- Muxes the granted requester's command, bank and address onto the SDRAM bus, and drives write data onto DQ.
- Captures read data after CAS latency and presents it to the downstream FIR data path with a valid strobe.

Parameters:
- CAS_LAT, 3, CAS latency in clocks; must match the mode register set by init.
- BURST_LEN, 4, burst length in words; must match the mode register.
- DATA_W, 16, SDRAM DQ width.

Ports:
- sys_clk  in  1  system/SDRAM clock
- sys_rst  in  1  asynchronous reset, active-high
- init_end  in  1  init sequence complete (level)
- init_cmd  in  4  init command {cs_n,ras_n,cas_n,we_n}
- init_ba  in  2  init bank
- init_addr  in  12  init address
- aref_req  in  1  refresh request
- aref_end  in  1  refresh done pulse
- aref_cmd  in  4  refresh command
- aref_addr  in  12  refresh address
- wr_req  in  1  write request
- wr_end  in  1  write done pulse
- wr_cmd  in  4  write command
- wr_ba  in  2  write bank
- wr_addr  in  12  write address
- wr_data  in  DATA_W  write data
- wr_data_oe  in  1  write source drives DQ
- rd_req  in  1  read request
- rd_end  in  1  read done pulse
- rd_cmd  in  4  read command
- rd_ba  in  2  read bank
- rd_addr  in  12  read address
- aref_en  out  1  refresh grant (level)
- wr_en  out  1  write grant (level)
- rd_en  out  1  read grant (level)
- sdram_cke  out  1  clock enable
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins
- sdram_ba  out  2  bank
- sdram_addr  out  12  address
- sdram_dq_out  out  DATA_W  DQ drive value
- sdram_dq_oe  out  1  DQ output enable
- sdram_dq_in  in  DATA_W  DQ sampled value
- rd_data  out  DATA_W  captured read word
- rd_data_vld  out  1  rd_data valid strobe

Behaviour:
- Reset values: state = INIT; all grants 0; sdram_cke = 1; command pins = NOP (0111); sdram_ba = 0; sdram_addr = 0; sdram_dq_oe = 0; sdram_dq_out = 0; rd_data = 0; rd_data_vld = 0; CAS pipeline cleared. Reset mid-operation aborts any grant immediately.
- FSM states: INIT, ARBIT, AREF, WRITE, READ. All transitions are registered.
  - INIT -> ARBIT when init_end = 1.
  - ARBIT: aref_req -> AREF; else wr_req -> WRITE; else rd_req -> READ; else stay. Requests seen on the same cycle resolve by priority.
  - AREF -> ARBIT on aref_end.
  - WRITE -> ARBIT on wr_end.
  - READ -> ARBIT on rd_end.
  - A *_end pulse arriving while its state is not active is ignored.
  - A granted state is never pre-empted. A requester must release by itself; the read and write modules precharge and end on ref_req.
- Grants: aref_en = (state == AREF), wr_en = (state == WRITE), rd_en = (state == READ). Each grant is registered and rises one cycle after the winning request is seen in ARBIT.
- Command mux (combinational from state):
  - INIT selects init_*.
  - AREF selects aref_* with ba = 0.
  - WRITE selects wr_*.
  - READ selects rd_*.
  - ARBIT drives NOP, ba = 0, addr = 0.
- DQ: sdram_dq_oe = wr_data_oe && state == WRITE; sdram_dq_out = wr_data.
- Read capture:
  - Detect READ command on the pins (cs_n,ras_n,cas_n,we_n = 0101) while state == READ.
  - Delay the detection through a CAS_LAT-deep shift register.
  - The shift-register output loads a burst counter with BURST_LEN.
  - While the counter is nonzero: register sdram_dq_in into rd_data, pulse rd_data_vld = 1, decrement the counter.
  - First valid word: rd_data_vld rises CAS_LAT+1 cycles after the READ command cycle, then stays high for BURST_LEN consecutive cycles.
  - A new READ command issued during a burst reloads the counter, giving gapless back-to-back bursts.
  - Capture continues after the state leaves READ, so in-flight data is never dropped.

Decomposition:
- Shared package sdram_pkg: command encodings (NOP 0111, ACT 0011, RD 0101, WR 0100, PRE 0010, AREF 0001, MRS 0000) and arbiter state encodings, shared with the init, refresh, write and read modules.
- One natural sub-module: sdram_rd_capture (CAS-latency shift register, burst counter, data register).

Test Plan:
- Reset asserted with init_end = 0: pins NOP, all grants 0. Release reset, assert init_end at cycle 10: state reaches ARBIT at cycle 11; no grant until a request arrives.
- aref_req, wr_req and rd_req asserted on the same cycle in ARBIT: aref_en = 1 next cycle. aref_end -> ARBIT, then wr_en = 1 the following cycle. wr_end -> ARBIT, then rd_en = 1.
- In READ, rd_cmd = 0101 at cycle T with sdram_dq_in = 0x0005, 0x0004, 0x0003, 0x0008 on cycles T+3..T+6: rd_data_vld is high on T+4..T+7 with exactly those values.
- Two READ commands 4 cycles apart: rd_data_vld stays high for 8 consecutive cycles, no gap.
- wr_req held during READ: no pre-emption. wr_en rises exactly 2 cycles after the rd_end pulse; sdram_dq_oe = 1 only while WRITE and wr_data_oe are both set.
- sys_rst asserted mid-burst in READ: grants, rd_data_vld and command pins return to reset values asynchronously; the pipeline is empty after release.
